clock_psc_mc: RTL and testbench
===============================

CLOCK_PSC_MC -- requirements
Module: clock_psc_mc

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent prescaler channels (1..16).
REQ-002 SHALL have parameter W, default 8, width of each channel's limit and counter (2..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  CH  per-channel enable, bit i controls channel i.
REQ-006 SHALL have port lim  input  CH*W  per-channel limit, channel i at bits [i*W +: W].
REQ-007 SHALL have port sync  input  1  phase-align strobe, present only when CLOCK_PSC_MC_SYNC_EN is defined.
REQ-008 SHALL have port hz  output  CH  per-channel divided square wave.
REQ-009 SHALL have port tick  output  CH  per-channel one-cycle pulse, asserted on the toggle cycle.

Function
REQ-010 Each channel SHALL hold an active limit register alim (W bits), a counter cnt (W bits) and the output hz.
REQ-011 A channel is running when en[i]=1 and alim!=0; a running channel SHALL increment cnt by 1 each cycle.
REQ-012 When running and cnt==alim, the next edge SHALL set cnt=0, invert hz and assert tick for exactly that one cycle.
REQ-013 The hz half-period SHALL be alim+1 cycles and the full period 2*(alim+1); tick SHALL assert once per half-period.
REQ-014 lim SHALL be sampled into alim only at the wrap edge (cnt==alim), and on every edge while the channel is not running; mid-period lim changes SHALL NOT alter the current half-period.
REQ-015 When en[i]=0, the next edge SHALL set cnt=0, hz=0 and tick=0, and SHALL load alim from lim.
REQ-016 When alim==0 with en[i]=1, the channel SHALL hold cnt=0, hz=0 and tick=0, and SHALL reload alim each cycle; it starts running the cycle after a nonzero lim is loaded.
REQ-017 On en rising, the first toggle SHALL occur alim+1 edges after the first edge on which en=1 is sampled.
REQ-018 cnt SHALL never exceed alim; no wrap past 2^W-1 can occur, because alim is at most 2^W-1.
REQ-019 Channels SHALL be fully independent; all tick and hz outputs SHALL be registered with no combinational path from inputs.

Reset
REQ-020 While rst_n=0 on a clock edge, all channels SHALL set cnt=0, alim=0, hz=0 and tick=0.
REQ-021 Reset SHALL override every other input, including mid-period, and SHALL take effect on the first edge it is sampled low.
REQ-022 After rst_n rises, each channel SHALL behave as in REQ-016 until a nonzero lim is loaded.

Configuration
REQ-023 With CLOCK_PSC_MC_SYNC_EN defined, sync=1 at an edge SHALL set cnt=0, hz=0 and tick=0 on all channels and SHALL load alim from lim, so all enabled channels restart in phase.
REQ-024 When sync coincides with a wrap (cnt==alim), sync SHALL win: no tick and no hz toggle that cycle.
REQ-025 When sync coincides with rst_n=0, reset SHALL win.
REQ-026 Without CLOCK_PSC_MC_SYNC_EN, the sync port and its logic SHALL be absent and the behaviour SHALL follow REQ-010..022 only.

Structure
REQ-027 Package clock_psc_pkg SHALL hold the default CH and W constants and the legal range bounds for CH and W.
REQ-028 A sub-module clock_psc_ch SHALL implement one channel (alim, cnt, hz, tick); clock_psc_mc SHALL instantiate it CH times through a generate loop.

Verification
REQ-029 Limit: W=8, lim[0]=3, en[0]=1 after reset -> tick[0] every 4 cycles, hz[0] period 8 cycles, first toggle 4 edges after en is sampled.
REQ-030 Shadowing: lim[1]=9 running; change to 2 at cnt=5 -> current half-period still 10 cycles, following half-periods 3 cycles.
REQ-031 Zero and disable: lim[2]=0 with en=1 -> hz=0, tick=0 held; set lim=1 -> toggles every 2 cycles; drop en mid-period -> hz=0 and cnt=0 on the next edge.
REQ-032 Width edge: W=4, lim=15 -> half-period 16 cycles, cnt never exceeds 15, no spurious tick.
REQ-033 Sync (macro on): channels with lim 2 and 4 running out of phase; pulse sync on a wrap cycle of channel 0 -> no tick that cycle, both hz=0, next ticks at +3 and +5 edges.
REQ-034 Reset: assert rst_n=0 mid-period with hz=1 -> all hz=0 and tick=0 on that edge; release -> channels idle until a nonzero lim is loaded, then resume per REQ-017.

Source files
------------

// File: rtl/clock_psc_pkg.sv
// clock_psc_pkg: default sizes and legal parameter ranges for the multi-channel prescaler.
package clock_psc_pkg;
  localparam int CH_DEF = 4;
  localparam int W_DEF  = 8;
  localparam int CH_MIN = 1;
  localparam int CH_MAX = 16;
  localparam int W_MIN  = 2;
  localparam int W_MAX  = 32;
endpackage

// File: rtl/clock_psc_ch.sv
// clock_psc_ch: one prescaler channel; limit is shadowed and only reloaded at wrap or while idle.
// Optional phase-align input i_sync exists only with CLOCK_PSC_MC_SYNC_EN defined.
module clock_psc_ch import clock_psc_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_lim,
`ifdef CLOCK_PSC_MC_SYNC_EN
  input  logic         i_sync,
`endif
  output logic         o_hz,
  output logic         o_tick
);
  logic [W-1:0] r_alim, r_cnt;
  logic         r_hz, r_tick;
  logic         w_idle, w_wrap;
`ifdef CLOCK_PSC_MC_SYNC_EN
  assign w_idle = i_sync || !i_en || r_alim == '0;
`else
  assign w_idle = !i_en || r_alim == '0;
`endif
  assign w_wrap = r_cnt == r_alim;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alim <= '0;
      r_cnt  <= '0;
      r_hz   <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_idle) begin
      r_alim <= i_lim;
      r_cnt  <= '0;
      r_hz   <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_alim <= i_lim;
      r_cnt  <= '0;
      r_hz   <= ~r_hz;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end
  assign o_hz   = r_hz;
  assign o_tick = r_tick;
endmodule

// File: rtl/clock_psc_mc.sv
// clock_psc_mc: CH independent clock prescalers, hz half-period = limit+1 cycles.
// Define CLOCK_PSC_MC_SYNC_EN to add the sync port that restarts all channels in phase.
module clock_psc_mc import clock_psc_pkg::*; #(
  parameter int CH = CH_DEF,
  parameter int W  = W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   en,
  input  logic [CH*W-1:0] lim,
`ifdef CLOCK_PSC_MC_SYNC_EN
  input  logic            sync,
`endif
  output logic [CH-1:0]   hz,
  output logic [CH-1:0]   tick
);
  for (genvar i = 0; i < CH; i++) begin : g_ch
    clock_psc_ch #(.W(W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (en[i]),
      .i_lim (lim[i*W +: W]),
`ifdef CLOCK_PSC_MC_SYNC_EN
      .i_sync(sync),
`endif
      .o_hz  (hz[i]),
      .o_tick(tick[i])
    );
  end
endmodule

// File: tb/tb_clock_psc_mc.sv
// tb_clock_psc_mc: directed scenarios plus randomized traffic against a deadline-based reference model.
module tb_clock_psc_mc;
  localparam int CH = 4;
  localparam int W  = 8;
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sync = 1'b0;
  logic [CH-1:0]   en = '0;
  logic [CH*W-1:0] lim = '0;
  logic [CH-1:0]   hz, tick;
  logic            en4 = 1'b0;
  logic [3:0]      lim4 = '0;
  logic [0:0]      hz4, tick4;
  int n_chk = 0, n_pass = 0, n_edge = 0;
  int m_alim[CH], m_due[CH];
  bit m_hz[CH], m_tick[CH], m_run[CH];
  int last4 = -1, n4 = 0;

  clock_psc_mc #(.CH(CH), .W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lim(lim),
`ifdef CLOCK_PSC_MC_SYNC_EN
    .sync(sync),
`endif
    .hz(hz), .tick(tick)
  );

  clock_psc_mc #(.CH(1), .W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .lim(lim4),
`ifdef CLOCK_PSC_MC_SYNC_EN
    .sync(1'b0),
`endif
    .hz(hz4), .tick(tick4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Model tracks the edge number of each channel's next toggle rather than a counter.
  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      int l;
      l = int'(lim[c*W +: W]);
      if (!rst_n) begin
        m_alim[c] = 0; m_hz[c] = 0; m_tick[c] = 0; m_run[c] = 0;
      end else if (sync || !en[c] || m_alim[c] == 0) begin
        m_alim[c] = l; m_hz[c] = 0; m_tick[c] = 0; m_run[c] = 0;
      end else begin
        if (!m_run[c]) begin
          m_run[c] = 1;
          m_due[c] = n_edge + m_alim[c];
        end
        m_tick[c] = (n_edge == m_due[c]);
        if (m_tick[c]) begin
          m_hz[c] = !m_hz[c];
          m_alim[c] = l;
          m_due[c] = n_edge + l + 1;
        end
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] eh, et;
    logic r;
    @(posedge clk);
    r = rst_n;
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      eh[c] = m_hz[c];
      et[c] = m_tick[c];
    end
    chk("hz", hz, eh);
    chk("tick", tick, et);
    if (!r) last4 = -1;
    else if (tick4[0]) begin
      if (last4 >= 0) chk("w4_period", n_edge - last4, 16);
      last4 = n_edge;
      n4++;
    end
    n_edge++;
  endtask

  task automatic wait_tick(input int c, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!tick[c] && k < 300);
    if (!tick[c]) k = -1;
  endtask

  function automatic logic [W-1:0] rand_lim();
    int r;
    r = int'($urandom_range(0, 9));
    return W'(r < 7 ? $urandom_range(0, 6) : r < 9 ? $urandom_range(7, 20) : $urandom_range(0, 255));
  endfunction

  initial begin
    int k, first, cnt;
    repeat (3) step();
    rst_n = 1'b1;
    lim[0 +: W] = 8'd3;
    en4 = 1'b1;
    lim4 = 4'd15;
    repeat (2) step();
    en = 4'b0001;
    first = 0;
    cnt = 0;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (tick[0]) begin
        cnt++;
        if (first == 0) first = s;
      end
    end
    chk("ch0_first_toggle", first, 4);
    chk("ch0_tick_count", cnt, 10);
    lim[W +: W] = 8'd9;
    en[1] = 1'b1;
    wait_tick(1, k);
    repeat (5) step();
    lim[W +: W] = 8'd2;
    wait_tick(1, k);
    chk("shadow_current", k, 5);
    wait_tick(1, k);
    chk("shadow_next", k, 3);
    en[2] = 1'b1;
    repeat (5) step();
    chk("zero_hz", hz[2], 0);
    chk("zero_tick", tick[2], 0);
    lim[2*W +: W] = 8'd1;
    wait_tick(2, k);
    wait_tick(2, k);
    chk("lim1_period", k, 2);
    en[2] = 1'b0;
    step();
    chk("disable_hz", hz[2], 0);
    en = '1;
    repeat (3000) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 29) == 0) en[c] = ~en[c];
        if ($urandom_range(0, 19) == 0) lim[c*W +: W] = rand_lim();
      end
`ifdef CLOCK_PSC_MC_SYNC_EN
      sync = ($urandom_range(0, 49) == 0);
`endif
      step();
    end
    chk("w4_ticks_seen", n4 > 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
